// File: rtl/sprite_cmd_seq.sv
// Sprite/background/font command sequencer: host commands queue in a FIFO and issue as display-stage strobes or holds.
// Optional build macro VBLANK_GATE_EN: commands only start issuing while vblank is high.
module sprite_cmd_seq #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [23:0] cmd_data,
    input  logic        vblank,
    output logic [4:0]  sprite_sel,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        visable,
    output logic [1:0]  background_sel,
    output logic [10:0] fwaddr,
    output logic [3:0]  fwdata,
    output logic        load_pos,
    output logic        load_att,
    output logic        fwenable,
    output logic        bchange_active,
    output logic        fchange_active,
    output logic        busy,
    output logic        cmd_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;
    typedef struct packed {
        logic [2:0]  op;
        logic [23:0] data;
    } entry_t;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [AW:0]   r_wptr, r_rptr;
    logic          w_full, w_empty, w_push, w_pop, w_gate;
    entry_t        r_mem [FIFO_DEPTH];
    entry_t        r_cur;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic [4:0]  r_sprite_sel, w_sprite_sel_nxt;
    logic [9:0]  r_x, w_x_nxt;
    logic [8:0]  r_y, w_y_nxt;
    logic        r_visable, w_visable_nxt;
    logic [1:0]  r_bg_sel, w_bg_sel_nxt;
    logic [10:0] r_fwaddr, w_fwaddr_nxt;
    logic [3:0]  r_fwdata, w_fwdata_nxt;
    logic        r_load_pos, r_load_att, r_fwen, r_bchg, r_fchg, r_err;
    logic        w_load_pos_nxt, w_load_att_nxt, w_fwen_nxt, w_bchg_nxt, w_fchg_nxt, w_err_nxt;

    // Reset asserts immediately but releases two edges later, glitch-free for all downstream flops.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef VBLANK_GATE_EN
    assign w_gate = vblank;
`else
    logic w_unused;
    assign w_unused = vblank;
    assign w_gate   = 1'b1;
`endif

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign cmd_ready = w_rst_n & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty & w_gate;
    assign busy      = ~w_empty | (r_state != S_IDLE);

    // NOTE: storage array carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_100mhz) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_op, cmd_data};
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sprite_sel_nxt = r_sprite_sel;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_visable_nxt    = r_visable;
        w_bg_sel_nxt     = r_bg_sel;
        w_fwaddr_nxt     = r_fwaddr;
        w_fwdata_nxt     = r_fwdata;
        w_load_pos_nxt   = 1'b0;
        w_load_att_nxt   = 1'b0;
        w_fwen_nxt       = 1'b0;
        w_bchg_nxt       = 1'b0;
        w_fchg_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        case (r_state)
            S_IDLE: if (w_pop) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                w_state_nxt = S_IDLE;
                case (r_cur.op)
                    3'd0: begin
                        w_load_pos_nxt   = 1'b1;
                        w_sprite_sel_nxt = r_cur.data[23:19];
                        w_x_nxt          = r_cur.data[18:9];
                        w_y_nxt          = r_cur.data[8:0];
                    end
                    3'd1: begin
                        w_load_att_nxt   = 1'b1;
                        w_sprite_sel_nxt = r_cur.data[23:19];
                        w_visable_nxt    = r_cur.data[0];
                    end
                    3'd2: begin
                        w_bchg_nxt   = 1'b1;
                        w_bg_sel_nxt = r_cur.data[1:0];
                        w_state_nxt  = S_HOLD;
                        w_cnt_nxt    = CW'(HOLD_CYCLES - 1);
                    end
                    3'd3: begin
                        w_fwen_nxt   = 1'b1;
                        w_fwaddr_nxt = r_cur.data[14:4];
                        w_fwdata_nxt = r_cur.data[3:0];
                    end
                    3'd4: begin
                        w_fchg_nxt  = 1'b1;
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                    end
                    default: w_err_nxt = 1'b1;
                endcase
            end
            S_HOLD: begin
                // The active hold level already covers the current cycle, so expiry is at zero.
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_bchg_nxt = r_bchg;
                    w_fchg_nxt = r_fchg;
                    w_cnt_nxt  = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every sequential assignment is non-blocking so all state updates see pre-edge values.
    always_ff @(posedge clk_100mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_cur        <= '0;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sprite_sel <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_visable    <= 1'b0;
            r_bg_sel     <= '0;
            r_fwaddr     <= '0;
            r_fwdata     <= '0;
            r_load_pos   <= 1'b0;
            r_load_att   <= 1'b0;
            r_fwen       <= 1'b0;
            r_bchg       <= 1'b0;
            r_fchg       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_cur  <= r_mem[r_rptr[AW-1:0]];
            end
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sprite_sel <= w_sprite_sel_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_visable    <= w_visable_nxt;
            r_bg_sel     <= w_bg_sel_nxt;
            r_fwaddr     <= w_fwaddr_nxt;
            r_fwdata     <= w_fwdata_nxt;
            r_load_pos   <= w_load_pos_nxt;
            r_load_att   <= w_load_att_nxt;
            r_fwen       <= w_fwen_nxt;
            r_bchg       <= w_bchg_nxt;
            r_fchg       <= w_fchg_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign sprite_sel     = r_sprite_sel;
    assign x              = r_x;
    assign y              = r_y;
    assign visable        = r_visable;
    assign background_sel = r_bg_sel;
    assign fwaddr         = r_fwaddr;
    assign fwdata         = r_fwdata;
    assign load_pos       = r_load_pos;
    assign load_att       = r_load_att;
    assign fwenable       = r_fwen;
    assign bchange_active = r_bchg;
    assign fchange_active = r_fchg;
    assign cmd_err        = r_err;
endmodule
